// File: rtl/uart_tx_fifo.sv
// Circular word FIFO that feeds uart_tx one frame at a time through its
// i_dv/i_data strobe, holding off the next word until the frame in flight ends.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int p_WORD_LEN   = 8,
    parameter int p_DEPTH_LOG2 = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [p_WORD_LEN-1:0]   i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [p_DEPTH_LOG2:0]   o_count,
    output logic                    o_overflow,
    output logic                    o_dv,
    output logic [p_WORD_LEN-1:0]   o_data,
    input  logic                    i_tx_active,
    input  logic                    i_tx_done
);

    localparam int unsigned DEPTH = 2 ** p_DEPTH_LOG2;
    localparam logic [p_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {p_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACT,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [p_WORD_LEN-1:0]   mem [DEPTH];
    logic [p_DEPTH_LOG2-1:0] wr_ptr;
    logic [p_DEPTH_LOG2-1:0] rd_ptr;
    logic [p_DEPTH_LOG2:0]   count;
    logic                    wr_accept;
    logic                    pop;

    assign o_full    = (count == FULL_COUNT);
    assign o_empty   = (count == '0);
    assign o_count   = count;
    // Full is judged on the registered count, so a pop in the same cycle does not free a slot.
    assign wr_accept = i_wr_en && !o_full;
    assign pop       = (state == IDLE) && (count != '0);

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_dv       <= 1'b0;
            o_data     <= '0;
            state      <= IDLE;
        end else begin
            o_overflow <= i_wr_en && o_full;
            o_dv       <= 1'b0;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        o_data <= mem[rd_ptr];
                        o_dv   <= 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (i_tx_done) begin
                        state <= IDLE;
                    end else if (i_tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Active was high on entry, so seeing it low here means it fell.
                    if (i_tx_done || !i_tx_active) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based scoreboard plus a simple
// behavioural stand-in for uart_tx that answers each issue strobe with a frame.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int W     = 8;
    localparam int L     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         o_full, o_empty, o_overflow, o_dv;
    logic [L:0]   o_count;
    logic [W-1:0] o_data;
    logic         tx_active, tx_done;

    logic m_active = 1'b0, m_done = 1'b0;
    logic t_active = 1'b0, t_done = 1'b0;
    bit   tx_stall = 1'b0;

    assign tx_active = m_active | t_active;
    assign tx_done   = m_done | t_done;

    int checks = 0;
    int fails  = 0;

    uart_tx_fifo #(.p_WORD_LEN(W), .p_DEPTH_LOG2(L)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_dv        (o_dv),
        .o_data      (o_data),
        .i_tx_active (tx_active),
        .i_tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // Inputs as seen by the DUT at each rising edge.
    logic         s_wr, s_done;
    logic [W-1:0] s_data;
    always @(posedge clk) begin
        s_wr   <= wr_en;
        s_data <= wr_data;
        s_done <= tx_done;
    end

    // Scoreboard: stored words, whether the issuer has no frame outstanding,
    // and the last word handed to the transmitter.
    logic [W-1:0] m_q[$];
    logic [W-1:0] issued[$];
    bit           m_free = 1'b1;
    logic [W-1:0] m_last = '0;
    bit           exp_dv, exp_ovf;

    always @(negedge clk) begin
        if (rst) begin
            m_q.delete();
            m_free = 1'b1;
            m_last = '0;
        end else begin
            exp_dv  = m_free && (m_q.size() != 0);
            exp_ovf = s_wr && (m_q.size() == DEPTH);
            if (exp_dv) begin
                m_last = m_q.pop_front();
                m_free = 1'b0;
            end
            if (s_wr && !exp_ovf) m_q.push_back(s_data);
            if (s_done) m_free = 1'b1;

            checks++;
            if (o_dv !== exp_dv) begin
                fails++;
                $display("FAIL mon_dv t=%0t: got %b expected %b", $time, o_dv, exp_dv);
            end
            checks++;
            if (o_data !== m_last) begin
                fails++;
                $display("FAIL mon_data t=%0t: got %02h expected %02h", $time, o_data, m_last);
            end
            checks++;
            if (o_count !== (L+1)'(m_q.size())) begin
                fails++;
                $display("FAIL mon_count t=%0t: got %0d expected %0d", $time, o_count, m_q.size());
            end
            checks++;
            if (o_full !== (m_q.size() == DEPTH) || o_empty !== (m_q.size() == 0)) begin
                fails++;
                $display("FAIL mon_flags t=%0t: got full=%b empty=%b expected size %0d",
                         $time, o_full, o_empty, m_q.size());
            end
            checks++;
            if (o_overflow !== exp_ovf) begin
                fails++;
                $display("FAIL mon_overflow t=%0t: got %b expected %b", $time, o_overflow, exp_ovf);
            end
            if (o_dv) issued.push_back(o_data);
        end
    end

    // Transmitter stand-in: short random gap, random-length active period, then done.
    int tx_phase = 0;
    int tx_cnt   = 0;
    bit pending  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            pending  = 1'b0;
            tx_phase = 0;
        end else begin
            m_done = 1'b0;
            if (o_dv) pending = 1'b1;
            case (tx_phase)
                0: if (pending && !tx_stall) begin
                    pending  = 1'b0;
                    tx_cnt   = int'($urandom_range(0, 2));
                    tx_phase = 1;
                end
                1: if (tx_cnt == 0) begin
                    m_active = 1'b1;
                    tx_cnt   = int'($urandom_range(2, 8));
                    tx_phase = 2;
                end else tx_cnt--;
                default: if (tx_cnt == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    tx_phase = 0;
                end else tx_cnt--;
            endcase
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        wr_en = 1'b0; t_active = 1'b0; t_done = 1'b0; tx_stall = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        issued.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1 done = (m_q.size() == 0) && m_free && (tx_phase == 0);
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: got not drained after %0d cycles, expected drained", name, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_dv, o_overflow, o_empty, o_full} !== 4'b0010 || o_count !== '0 || o_data !== '0) begin
            fails++;
            $display("FAIL reset_values: got dv=%b ovf=%b empty=%b full=%b cnt=%0d data=%02h expected 0 0 1 0 0 00",
                     o_dv, o_overflow, o_empty, o_full, o_count, o_data);
        end
        #2 rst = 1'b0;
        issued.delete();
    endtask

    task automatic test_single_word();
        do_reset();
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (o_count !== 5'd1 || o_dv !== 1'b0) begin
            fails++;
            $display("FAIL single_stage1: got cnt=%0d dv=%b expected 1 0", o_count, o_dv);
        end
        @(negedge clk);
        checks++;
        if (o_dv !== 1'b1 || o_data !== 8'hEE || o_empty !== 1'b1) begin
            fails++;
            $display("FAIL single_issue: got dv=%b data=%02h empty=%b expected 1 ee 1", o_dv, o_data, o_empty);
        end
        @(negedge clk);
        checks++;
        if (o_dv !== 1'b0) begin
            fails++;
            $display("FAIL single_dv_width: got %b expected 0", o_dv);
        end
        wait_drain("single", 100);
    endtask

    task automatic test_burst();
        logic [W-1:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int peak = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = words[i];
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        @(negedge clk); wr_en = 1'b0;
        if (int'(o_count) > peak) peak = int'(o_count);
        wait_drain("burst", 300);
        checks++;
        if (peak != 3) begin
            fails++;
            $display("FAIL burst_peak: got %0d expected 3", peak);
        end
        checks++;
        if (issued.size() != 4) begin
            fails++;
            $display("FAIL burst_pulses: got %0d expected 4", issued.size());
        end
        for (int i = 0; i < 4 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== words[i]) begin
                fails++;
                $display("FAIL burst_order[%0d]: got %02h expected %02h", i, issued[i], words[i]);
            end
        end
    endtask

    task automatic test_fill_full();
        logic [W-1:0] words[17];
        do_reset();
        tx_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            words[i] = W'($urandom);
            @(negedge clk); wr_en = 1'b1; wr_data = words[i];
        end
        @(negedge clk); wr_data = 8'hA5;
        checks++;
        if (o_count !== 5'd16 || o_full !== 1'b1) begin
            fails++;
            $display("FAIL fill_full: got cnt=%0d full=%b expected 16 1", o_count, o_full);
        end
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
            fails++;
            $display("FAIL fill_overflow: got ovf=%b cnt=%0d expected 1 16", o_overflow, o_count);
        end
        @(negedge clk);
        checks++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL fill_ovf_pulse: got %b expected 0", o_overflow);
        end
        tx_stall = 1'b0;
        wait_drain("fill", 1000);
        checks++;
        if (issued.size() != 17) begin
            fails++;
            $display("FAIL fill_issued: got %0d expected 17", issued.size());
        end
        for (int i = 0; i < 17 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== words[i]) begin
                fails++;
                $display("FAIL fill_order[%0d]: got %02h expected %02h", i, issued[i], words[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000 && sent < 40; cyc++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (!o_full && $urandom_range(0, 2) == 0) begin
                wr_en   = 1'b1;
                wr_data = W'(sent);
                sent++;
            end
        end
        @(negedge clk); wr_en = 1'b0;
        wait_drain("wrap", 1000);
        checks++;
        if (issued.size() != 40) begin
            fails++;
            $display("FAIL wrap_issued: got %0d expected 40", issued.size());
        end
        for (int i = 0; i < 40 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== W'(i)) begin
                fails++;
                $display("FAIL wrap_order[%0d]: got %02h expected %02h", i, issued[i], W'(i));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] words[7];
        do_reset();
        tx_stall = 1'b1;
        for (int i = 0; i < 7; i++) words[i] = W'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = words[i];
        end
        @(negedge clk); wr_en = 1'b0; t_done = 1'b1;
        checks++;
        if (o_count !== 5'd5) begin
            fails++;
            $display("FAIL simul_pre: got cnt=%0d expected 5", o_count);
        end
        @(negedge clk); t_done = 1'b0; wr_en = 1'b1; wr_data = words[6];
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (o_count !== 5'd5 || o_dv !== 1'b1 || o_data !== words[1]) begin
            fails++;
            $display("FAIL simul_pop_write: got cnt=%0d dv=%b data=%02h expected 5 1 %02h",
                     o_count, o_dv, o_data, words[1]);
        end
        tx_stall = 1'b0;
        wait_drain("simul", 1000);
        checks++;
        if (issued.size() != 7) begin
            fails++;
            $display("FAIL simul_issued: got %0d expected 7", issued.size());
        end
        for (int i = 0; i < 7 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== words[i]) begin
                fails++;
                $display("FAIL simul_order[%0d]: got %02h expected %02h", i, issued[i], words[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        tx_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = W'($urandom);
        end
        @(negedge clk); wr_en = 1'b0; t_active = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_count !== 5'd3) begin
            fails++;
            $display("FAIL midrst_pre: got cnt=%0d expected 3", o_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_dv, o_overflow, o_empty, o_full} !== 4'b0010 || o_count !== '0 || o_data !== '0) begin
            fails++;
            $display("FAIL midrst_async: got dv=%b ovf=%b empty=%b full=%b cnt=%0d data=%02h expected 0 0 1 0 0 00",
                     o_dv, o_overflow, o_empty, o_full, o_count, o_data);
        end
        t_active = 1'b0;
        tx_stall = 1'b0;
        @(negedge clk); #2 rst = 1'b0;
        issued.delete();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o_dv !== 1'b0 || o_count !== '0) begin
                fails++;
                $display("FAIL midrst_after: got dv=%b cnt=%0d expected 0 0", o_dv, o_count);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = W'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_drain("random", 2000);
        checks++;
        if (o_empty !== 1'b1 || o_count !== '0) begin
            fails++;
            $display("FAIL random_end: got empty=%b cnt=%0d expected 1 0", o_empty, o_count);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        test_reset();
        test_single_word();
        test_burst();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and issue sequencer sitting directly upstream of uart_tx.
- Accepts bursts of words from a host-side writer into a circular FIFO.
- Feeds uart_tx one word at a time through its i_dv/i_data strobe interface, holding off the next word until the frame in flight completes.
- Lets software-side logic queue a message without tracking uart_tx busy status.

Parameters:
- p_WORD_LEN, 8: data word width; must match uart_tx p_WORD_LEN.
- p_DEPTH_LOG2, 4: log2 of FIFO depth (default depth 16 entries).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  write strobe; one word accepted per cycle while high and not full.
- i_wr_data  input  p_WORD_LEN  word to enqueue.
- o_full  output  1  high when count == 2**p_DEPTH_LOG2.
- o_empty  output  1  high when count == 0.
- o_count  output  p_DEPTH_LOG2+1  number of stored words; excludes the word in flight.
- o_overflow  output  1  one-cycle pulse when a write is dropped.
- o_dv  output  1  one-cycle issue strobe to uart_tx i_dv.
- o_data  output  p_WORD_LEN  word to uart_tx i_data.
- i_tx_active  input  1  uart_tx o_active.
- i_tx_done  input  1  uart_tx o_done; one-cycle pulse at end of stop bit.

Behaviour:
- Reset (asynchronous, immediate):
  - Pointers = 0, count = 0, FSM = IDLE.
  - o_dv = 0, o_data = 0, o_overflow = 0, o_empty = 1, o_full = 0.
  - Storage contents are don't-care.
- Reset mid-frame: the queue and the in-flight word are abandoned. uart_tx is not reset by this block; the FSM restarts in IDLE and may issue before the old frame ends. Reset both blocks together.
- Storage and pointers:
  - Storage is 2**p_DEPTH_LOG2 words.
  - Write and read pointers are p_DEPTH_LOG2 bits and wrap naturally modulo depth.
  - count is registered: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- Write rule:
  - A write is accepted when i_wr_en=1 and registered o_full=0.
  - When full, the write is dropped and o_overflow pulses the next cycle, even if a pop occurs in the same cycle (full is evaluated before the pop).
  - Write and pop in the same cycle at any non-full level are both performed.
- FSM states:
  - IDLE: if count != 0, pop the head word into o_data and assert o_dv for exactly one cycle; go to ISSUE.
  - ISSUE: o_dv drops to 0; go to WAIT_ACT.
  - WAIT_ACT: wait for i_tx_active=1, then go to WAIT_DONE. If i_tx_done=1 arrives first, go to IDLE.
  - WAIT_DONE: wait for i_tx_done=1 (or i_tx_active falling 1->0), then go to IDLE.
- o_data is held stable from the o_dv cycle until the FSM returns to IDLE.
- Pop occurs on the edge that raises o_dv; the read pointer increments there.
- Latency:
  - Write into an empty, idle FIFO sampled at edge N: count=1 after N, o_dv=1 after edge N+1, o_dv=0 after N+2.
  - Back-to-back frames: o_dv for the next word rises one edge after the edge sampling i_tx_done. IDLE then re-issues immediately.
- Words leave in strict FIFO order. No word is duplicated or skipped across pointer wrap.
- o_empty and o_full are derived from the registered count, so they are valid the cycle after the write or pop.

Test Plan:
- Single word: reset, write 0xEE once, uart_tx downstream with p_CLK_DIV=10 -> o_dv single pulse two edges after the write, o_data=0xEE, uart_rx captures 0xEE, o_empty=1 after pop.
- Burst of 4 (0x11, 0x22, 0x33, 0x44) on consecutive cycles -> o_count peaks at 3; four frames transmitted in order; exactly four o_dv pulses, each one edge after the previous i_tx_done; uart_rx sequence 11, 22, 33, 44.
- Fill to full: hold i_tx_active stimulus low and i_tx_done never pulsing, write 17 words while FSM is stuck in WAIT_ACT -> one word in flight, o_count=16, o_full=1, 17th write accepted-or-dropped per full rule; an 18th write while full -> o_overflow one pulse, count stays 16.
- Wrap-around: write and drain 40 words with values 0..39 through the real uart_tx -> received sequence 0..39 in order with no gaps; pointers wrap twice.
- Simultaneous write and pop at count=5 -> count remains 5, written word appears later in correct order.
- Reset mid-frame: assert i_rst while WAIT_DONE with count=3 -> outputs immediately at reset values, o_count=0, no o_dv for 1 cycle after release while empty.
